// File: rtl/dm_cache_def.sv
// Shared bus payload types between the direct-mapped cache and its memory model.
package dm_cache_def;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_data_type;

endpackage

// File: rtl/dm_cache_mem.sv
// Line-granular backing memory with fixed read/write latency, one request in flight.
module dm_cache_mem
   import dm_cache_def::*;
#(
   parameter int unsigned MEM_LINES     = 1024,
   parameter int unsigned READ_LATENCY  = 4,
   parameter int unsigned WRITE_LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  mem_req_type  mem_req,
   output mem_data_type mem_data,
   output logic         busy,
   output logic         req_dropped,
   output logic [31:0]  rd_count,
   output logic [31:0]  wr_count
);

   localparam int unsigned IDX_W   = $clog2(MEM_LINES);
   localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [127:0]       wdata_q, wdata_d;
   logic               rw_q, rw_d;
   logic [127:0]       rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               dropped_q, dropped_d;
   logic [31:0]        rd_count_q, rd_count_d;
   logic [31:0]        wr_count_q, wr_count_d;

   logic               accept_c;
   logic               mem_we_c;
   int unsigned        lat_c;

   // Backing store starts zeroed; reset intentionally leaves contents alone.
   logic [127:0]       mem_q [MEM_LINES] = '{default: '0};

   // Address bits outside the line index are don't-care (aliasing is intended).
   logic               unused_addr_c;
   assign unused_addr_c = ^{mem_req.addr[31:IDX_W+4], mem_req.addr[3:0]};

   // The write commits at the end of its completion cycle.
   assign mem_we_c = (state_q == S_DONE) && rw_q;

   // Next-state, request latch, read capture and counters.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rw_d       = rw_q;
      rdata_d    = rdata_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      dropped_d  = dropped_q | (mem_req.valid && (state_q == S_WAIT));
      accept_c   = 1'b0;
      lat_c      = READ_LATENCY;

      case (state_q)
         S_IDLE: accept_c = mem_req.valid;
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d  = S_IDLE;
            accept_c = mem_req.valid;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept_c) begin
         idx_d   = mem_req.addr[IDX_W+3:4];
         wdata_d = mem_req.data;
         rw_d    = mem_req.rw;
         lat_c   = mem_req.rw ? WRITE_LATENCY : READ_LATENCY;
         cnt_d   = CNT_W'(lat_c - 32'd1);
         state_d = (lat_c == 32'd1) ? S_DONE : S_WAIT;
      end

      // Read data is sampled on entry to DONE, forwarding a write committing this cycle.
      if (state_d == S_DONE) begin
         if (rw_d) begin
            wr_count_d = wr_count_q + 32'd1;
         end else begin
            rd_count_d = rd_count_q + 32'd1;
            rdata_d    = (mem_we_c && (idx_q == idx_d)) ? wdata_q : mem_q[idx_d];
         end
      end

      ready_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         rw_q       <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         rw_q       <= rw_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Line write; a reset in the completion cycle cancels the commit.
   always_ff @(posedge clk) begin
      if (!rst && mem_we_c) mem_q[idx_q] <= wdata_q;
   end

   assign mem_data    = '{data: rdata_q, ready: ready_q};
   assign busy        = busy_q;
   assign req_dropped = dropped_q;
   assign rd_count    = rd_count_q;
   assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_dm_cache_mem.sv
// Scoreboard bench for dm_cache_mem: a latency-4 instance and a latency-1 instance.
module tb_dm_cache_mem;
   import dm_cache_def::*;

   localparam int unsigned MEM_LINES = 1024;

   logic         clk = 1'b0;
   logic         rst;
   mem_req_type  req0, req1;
   mem_data_type md0, md1;
   logic         busy0, busy1, drop0, drop1;
   logic [31:0]  rdc0, rdc1, wrc0, wrc1;

   dm_cache_mem #(.MEM_LINES(MEM_LINES), .READ_LATENCY(4), .WRITE_LATENCY(4)) u_dut0 (
      .clk(clk), .rst(rst), .mem_req(req0), .mem_data(md0), .busy(busy0),
      .req_dropped(drop0), .rd_count(rdc0), .wr_count(wrc0));

   dm_cache_mem #(.MEM_LINES(MEM_LINES), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_req(req1), .mem_data(md1), .busy(busy1),
      .req_dropped(drop1), .rd_count(rdc1), .wr_count(wrc1));

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           id;
      logic         rw;
      logic [127:0] data;
      int unsigned  due;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] ref0 [int];
   logic [127:0] ref1 [int];
   logic [127:0] last_rd [2];
   int unsigned  exp_rd [2];
   int unsigned  exp_wr [2];
   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int unsigned lat_of(input int id);
      return (id == 0) ? 4 : 1;
   endfunction

   function automatic logic [127:0] ref_rd(input int id, input int idx);
      if (id == 0) return ref0.exists(idx) ? ref0[idx] : '0;
      return ref1.exists(idx) ? ref1[idx] : '0;
   endfunction

   // Drive a request this cycle; push its expected response when the model should see it.
   task automatic issue(input int id, input logic rw, input logic [31:0] addr,
                        input logic [127:0] data, input bit push);
      mem_req_type r;
      exp_t        e;
      int          idx;
      r.addr = addr; r.data = data; r.rw = rw; r.valid = 1'b1;
      if (id == 0) req0 = r; else req1 = r;
      if (push) begin
         idx    = int'((addr >> 4) & (MEM_LINES - 1));
         e.id   = id;
         e.rw   = rw;
         e.due  = cyc + lat_of(id);
         e.data = rw ? data : ref_rd(id, idx);
         if (rw) begin
            if (id == 0) ref0[idx] = data; else ref1[idx] = data;
         end
         sb.push_back(e);
      end
   endtask

   task automatic clear_req(input int id);
      if (id == 0) req0.valid = 1'b0; else req1.valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
      tick(2);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         last_rd[i] = '0; exp_rd[i] = 0; exp_wr[i] = 0;
      end
   endtask

   // Pop and compare the expected response for a completion pulse.
   task automatic mon(input int id, input logic rdy, input logic [127:0] d,
                      input logic [31:0] rc, input logic [31:0] wc);
      exp_t e;
      if (sb.size() == 0) begin
         chk("unexpected_ready", 128'(rdy), 128'(0));
         return;
      end
      e = sb.pop_front();
      chk("resp_dut", 128'(id), 128'(e.id));
      chk("resp_cycle", 128'(cyc), 128'(e.due));
      if (!e.rw) begin
         last_rd[id] = e.data;
         exp_rd[id]++;
      end else begin
         exp_wr[id]++;
      end
      chk("resp_data", d, last_rd[id]);
      chk("rd_count", 128'(rc), 128'(exp_rd[id]));
      chk("wr_count", 128'(wc), 128'(exp_wr[id]));
   endtask

   always @(negedge clk) begin
      if (md0.ready) mon(0, md0.ready, md0.data, rdc0, wrc0);
      if (md1.ready) mon(1, md1.ready, md1.data, rdc1, wrc1);
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   localparam logic [127:0] PAT  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [127:0] PAT2 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] PAT3 = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;

   initial begin
      rst  = 1'b1;
      req0 = '0;
      req1 = '0;
      model_reset();
      tick(3);
      chk("rst_ready", 128'(md0.ready), 128'(0));
      chk("rst_data", md0.data, 128'(0));
      chk("rst_busy", 128'(busy0), 128'(0));
      chk("rst_dropped", 128'(drop0), 128'(0));
      chk("rst_rd_count", 128'(rdc0), 128'(0));
      chk("rst_wr_count", 128'(wrc0), 128'(0));
      chk("rst_busy1", 128'(busy1), 128'(0));
      rst = 1'b0;
      tick(1);

      // Cold read: latency 4, zero data
      issue(0, 1'b0, 32'h0000_0040, '0, 1'b1);
      tick(1); clear_req(0);
      chk("wait_busy", 128'(busy0), 128'(1));
      drain();

      // Write then read with offset bits, then aliased read
      issue(0, 1'b1, 32'h0000_0100, PAT, 1'b1);
      tick(1); clear_req(0); drain();
      issue(0, 1'b0, 32'h0000_010C, '0, 1'b1);
      tick(1); clear_req(0); drain();
      issue(0, 1'b0, 32'h0000_0100 + 32'(MEM_LINES * 16), '0, 1'b1);
      tick(1); clear_req(0); drain();
      chk("idle_busy", 128'(busy0), 128'(0));

      // Write-back then allocate issued in the write's ready cycle
      issue(0, 1'b1, 32'h0000_0200, PAT2, 1'b1);
      tick(1); clear_req(0);
      for (int i = 1; i <= 8; i++) begin
         chk("b2b_busy", 128'(busy0), 128'(1));
         if (i == 4) issue(0, 1'b0, 32'h0000_0300, '0, 1'b1);
         if (i == 5) clear_req(0);
         tick(1);
      end
      drain();

      // Request during WAIT is dropped and flagged
      issue(0, 1'b0, 32'h0000_0100, '0, 1'b1);
      tick(1); clear_req(0);
      tick(1);
      issue(0, 1'b1, 32'h0000_0700, PAT3, 1'b0);
      tick(1); clear_req(0);
      drain();
      chk("dropped_set", 128'(drop0), 128'(1));

      // Reset two cycles after a write accept; valid during reset ignored
      issue(0, 1'b1, 32'h0000_0100, PAT3, 1'b0);
      tick(1); clear_req(0);
      tick(1);
      rst = 1'b1;
      issue(0, 1'b0, 32'h0000_0040, '0, 1'b0);
      tick(1);
      rst = 1'b0;
      clear_req(0);
      model_reset();
      chk("mid_rst_rd_count", 128'(rdc0), 128'(0));
      chk("mid_rst_wr_count", 128'(wrc0), 128'(0));
      chk("mid_rst_dropped", 128'(drop0), 128'(0));
      chk("mid_rst_busy", 128'(busy0), 128'(0));
      chk("mid_rst_data", md0.data, 128'(0));
      tick(6);
      issue(0, 1'b0, 32'h0000_0100, '0, 1'b1);
      tick(1); clear_req(0); drain();

      // Latency-1 instance: valid held for alternating write/read
      for (int i = 0; i < 5; i++) begin
         if (i >= 1) chk("l1_ready", 128'(md1.ready), 128'(1));
         issue(1, (i % 2) == 0, 32'h0000_0500 + 32'((i / 2) * 16),
               {4{32'hA5A5_0000 + 32'(i)}}, 1'b1);
         tick(1);
      end
      clear_req(1);
      chk("l1_ready_last", 128'(md1.ready), 128'(1));
      drain();
      chk("l1_rd_total", 128'(rdc1), 128'(2));
      chk("l1_wr_total", 128'(wrc1), 128'(3));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
